// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV64I decode/issue stage feeding the ALU.
// Decodes the fetched instruction, reads the register file combinationally and
// holds the ALU operands/controls in a single valid/ready issue register.
// A small counter stalls instructions that depend on a load that just issued.
// Optional feature macro: ALU_ISSUE_BYPASS_EN (writeback-to-decode forwarding).
module alu_issue_stage #(
  parameter int XLEN             = 64,
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] op0,
  output logic [XLEN-1:0] op1,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic [6:0]      ctrl,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] rs2_val,
  output logic            illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] BUBBLES = 2'(LOAD_USE_BUBBLES);

  // Instruction fields
  logic [6:0] opc;
  logic [2:0] f3;
  logic [4:0] rd_f;
  assign opc      = in_instr[6:0];
  assign f3       = in_instr[14:12];
  assign rd_f     = in_instr[11:7];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  // Sign-extended immediates for each format
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));

  // Source operand selection (optional writeback forwarding, then x0 forcing)
  logic            byp1, byp2;
  logic [XLEN-1:0] rs1_raw, rs2_raw, rs1_val, rs2_v;
`ifdef ALU_ISSUE_BYPASS_EN
  assign byp1    = wb_en && (wb_rd != 5'd0) && (wb_rd == rs1_addr);
  assign byp2    = wb_en && (wb_rd != 5'd0) && (wb_rd == rs2_addr);
  assign rs1_raw = byp1 ? wb_data : rs1_data;
  assign rs2_raw = byp2 ? wb_data : rs2_data;
`else
  // Regfile is write-before-read; writeback port is not observed.
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_rd, wb_data};
  assign byp1    = 1'b0;
  assign byp2    = 1'b0;
  assign rs1_raw = rs1_data;
  assign rs2_raw = rs2_data;
`endif
  assign rs1_val = (rs1_addr == 5'd0) ? '0 : rs1_raw;
  assign rs2_v   = (rs2_addr == 5'd0) ? '0 : rs2_raw;

  // Issue register and load-use state
  logic            valid_q;
  logic [XLEN-1:0] op0_q, op1_q, imm_q, rs2v_q;
  logic [2:0]      func3_q;
  logic [6:0]      func7_q, ctrl_q;
  logic [4:0]      rd_q, ld_rd_q;
  logic            illegal_q;
  logic [1:0]      cnt_q;

  // Load-use hazard: a source still waiting on the last issued load.
  // A forwarded source already carries the fresh value, so it cannot stall.
  logic rs1_used, rs2_used, hazard, accept, fire;
  assign rs1_used = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
  assign rs2_used = (opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH);
  assign hazard   = (cnt_q != 2'd0) && in_valid &&
                    ((rs1_used && !byp1 && rs1_addr == ld_rd_q) ||
                     (rs2_used && !byp2 && rs2_addr == ld_rd_q));

  assign in_ready = rst_n && !flush && !hazard && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign fire     = valid_q && out_ready;

  // Next-state decode of the incoming instruction
  logic [XLEN-1:0] op0_d, op1_d, imm_d;
  logic [6:0]      func7_d, ctrl_d;
  logic [4:0]      rd_d;
  logic            illegal_d;

  // Decode opcode into operands and control bits
  always_comb begin
    op0_d     = '0;
    op1_d     = '0;
    imm_d     = '0;
    func7_d   = 7'd0;
    ctrl_d    = 7'd0;
    rd_d      = rd_f;
    illegal_d = 1'b0;
    unique case (opc)
      OPC_OP: begin
        op0_d = rs1_val; op1_d = rs2_v;
        func7_d = in_instr[31:25]; ctrl_d = 7'b1100000;
      end
      OPC_OPIMM: begin
        op0_d = rs1_val; op1_d = imm_i; imm_d = imm_i; ctrl_d = 7'b1100000;
        // Only shifts carry a funct7 (shamt[5] lives in bit 25); ADDI must not look like SUB.
        if (f3 == 3'b001 || f3 == 3'b101) func7_d = {in_instr[31:26], 1'b0};
      end
      OPC_LOAD: begin
        op0_d = rs1_val; op1_d = imm_i; imm_d = imm_i; ctrl_d = 7'b0100100;
      end
      OPC_STORE: begin
        op0_d = rs1_val; op1_d = imm_s; imm_d = imm_s; ctrl_d = 7'b0001000; rd_d = 5'd0;
      end
      OPC_BRANCH: begin
        op0_d = rs1_val; op1_d = rs2_v; imm_d = imm_b; ctrl_d = 7'b0000001; rd_d = 5'd0;
      end
      OPC_JAL: begin
        op0_d = in_pc; op1_d = XLEN'(4); imm_d = imm_j; ctrl_d = 7'b0100010;
      end
      OPC_JALR: begin
        op0_d = in_pc; op1_d = XLEN'(4); imm_d = imm_i; ctrl_d = 7'b0100010;
      end
      OPC_LUI: begin
        op1_d = imm_u; imm_d = imm_u; ctrl_d = 7'b0110000;
      end
      OPC_AUIPC: begin
        op0_d = in_pc; op1_d = imm_u; imm_d = imm_u; ctrl_d = 7'b0110000;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  // Issue register: flush kills, accept loads, fire alone drains
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      op0_q     <= '0;
      op1_q     <= '0;
      imm_q     <= '0;
      rs2v_q    <= '0;
      func3_q   <= 3'd0;
      func7_q   <= 7'd0;
      ctrl_q    <= 7'd0;
      rd_q      <= 5'd0;
      illegal_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q   <= 1'b1;
      op0_q     <= op0_d;
      op1_q     <= op1_d;
      imm_q     <= imm_d;
      rs2v_q    <= rs2_v;
      func3_q   <= f3;
      func7_q   <= func7_d;
      ctrl_q    <= ctrl_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
    end else if (fire) begin
      valid_q <= 1'b0;
    end
  end

  // Load-use counter: arm when a load with a real destination leaves, else count down
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= 2'd0;
      ld_rd_q <= 5'd0;
    end else if (flush) begin
      cnt_q <= 2'd0;
    end else if (fire && ctrl_q[2] && rd_q != 5'd0) begin
      cnt_q   <= BUBBLES;
      ld_rd_q <= rd_q;
    end else if (cnt_q != 2'd0) begin
      cnt_q <= cnt_q - 2'd1;
    end
  end

  assign out_valid = valid_q;
  assign op0       = op0_q;
  assign op1       = op1_q;
  assign func3     = func3_q;
  assign func7     = func7_q;
  assign ctrl      = ctrl_q;
  assign rd        = rd_q;
  assign imm       = imm_q;
  assign rs2_val   = rs2v_q;
  assign illegal   = illegal_q && valid_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus a randomized run checked
// against an instruction-level reference model (decode table + hazard window).
module tb_alu_issue_stage;

  localparam int XLEN = 64;
  localparam int BUB  = 1;

  localparam logic [31:0] I_ADD      = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] I_ADDI     = 32'hC0000093; // addi x1,x0,-1024
  localparam logic [31:0] I_SRAI     = 32'h40315093; // srai x1,x2,3
  localparam logic [31:0] I_LW5      = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] I_LW7      = 32'h0000A383; // lw   x7,0(x1)
  localparam logic [31:0] I_ADD_DEP  = 32'h00128333; // add  x6,x5,x1
  localparam logic [31:0] I_ADD_IND  = 32'h00120333; // add  x6,x4,x1
  localparam logic [31:0] I_ADD_DEP7 = 32'h00138333; // add  x6,x7,x1

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, in_valid, in_ready, wb_en, flush, out_valid, out_ready, illegal;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc, rs1_data, rs2_data, wb_data, op0, op1, imm, rs2_val;
  logic [4:0]      rs1_addr, rs2_addr, wb_rd, rd;
  logic [2:0]      func3;
  logic [6:0]      func7, ctrl;
  logic [63:0]     rf [32];

  assign rs1_data = rf[in_instr[19:15]];
  assign rs2_data = rf[in_instr[24:20]];

  alu_issue_stage #(.XLEN(XLEN), .LOAD_USE_BUBBLES(BUB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .op0(op0), .op1(op1), .func3(func3), .func7(func7), .ctrl(ctrl), .rd(rd),
    .imm(imm), .rs2_val(rs2_val), .illegal(illegal)
  );

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [63:0] op0, op1, imm, rs2v;
    logic [2:0]  f3;
    logic [6:0]  f7, ctrl;
    logic [4:0]  rd;
    logic        ill, chk_imm, chk_f7;
  } dec_t;

  // Reference model state
  logic m_valid;
  dec_t m_dec;
  int   m_cnt, m_ld;

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] rdval(input logic [4:0] a);
    return (a == 5'd0) ? 64'd0 : rf[a];
  endfunction

  // Instruction-level decode: immediates built with plain signed arithmetic
  function automatic dec_t ref_dec(input logic [31:0] ins, input logic [63:0] pc,
                                   input logic [63:0] r1, input logic [63:0] r2);
    dec_t d;
    int signed w;
    longint iimm, simm, bimm, jimm, uimm;
    w    = ins;
    iimm = longint'(w >>> 20);
    simm = longint'(w >>> 25) * 32 + longint'(ins[11:7]);
    bimm = longint'(w >>> 31) * 4096 + longint'(ins[7]) * 2048 +
           longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
    jimm = longint'(w >>> 31) * 1048576 + longint'(ins[19:12]) * 4096 +
           longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
    uimm = longint'(w >>> 12) * 4096;
    d = '0;
    d.f3 = ins[14:12]; d.rd = ins[11:7]; d.rs2v = r2;
    case (ins[6:0])
      7'h33: begin d.op0 = r1; d.op1 = r2; d.f7 = ins[31:25]; d.ctrl = 7'h60; d.chk_f7 = 1; end
      7'h13: begin
        d.op0 = r1; d.op1 = iimm; d.ctrl = 7'h60; d.chk_f7 = 1;
        d.f7 = (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) ? (ins[31:25] & 7'h7E) : 7'd0;
      end
      7'h03: begin d.op0 = r1; d.op1 = iimm; d.ctrl = 7'h24; end
      7'h23: begin d.op0 = r1; d.op1 = simm; d.ctrl = 7'h08; d.rd = 0; end
      7'h63: begin d.op0 = r1; d.op1 = r2; d.imm = bimm; d.chk_imm = 1; d.ctrl = 7'h01; d.rd = 0; end
      7'h6F: begin d.op0 = pc; d.op1 = 64'd4; d.imm = jimm; d.chk_imm = 1; d.ctrl = 7'h22; end
      7'h67: begin d.op0 = pc; d.op1 = 64'd4; d.imm = iimm; d.chk_imm = 1; d.ctrl = 7'h22; end
      7'h37: begin d.op1 = uimm; d.ctrl = 7'h30; end
      7'h17: begin d.op0 = pc; d.op1 = uimm; d.ctrl = 7'h30; end
      default: d.ill = 1;
    endcase
    return d;
  endfunction

  // Would the model accept the presented instruction this cycle?
  function automatic logic ref_ready();
    logic [6:0] o;
    logic u1, u2, hz;
    o  = in_instr[6:0];
    u1 = !(o == 7'h37 || o == 7'h17 || o == 7'h6F);
    u2 = (o == 7'h33 || o == 7'h23 || o == 7'h63);
    hz = (m_cnt > 0) && in_valid &&
         ((u1 && int'(in_instr[19:15]) == m_ld) || (u2 && int'(in_instr[24:20]) == m_ld));
    return !flush && !hz && (!m_valid || out_ready);
  endfunction

  // Advance the model across one clock edge using the current inputs
  task automatic model_edge();
    logic acc, fire;
    acc  = in_valid && ref_ready();
    fire = m_valid && out_ready;
    if (flush) begin
      m_valid = 0; m_cnt = 0;
    end else begin
      if (fire && m_dec.ctrl[2] && m_dec.rd != 0) begin m_ld = int'(m_dec.rd); m_cnt = BUB; end
      else if (m_cnt > 0) m_cnt--;
      if (acc) begin
        m_valid = 1;
        m_dec = ref_dec(in_instr, in_pc, rdval(in_instr[19:15]), rdval(in_instr[24:20]));
      end else if (fire) m_valid = 0;
    end
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] ins;
    ins = $urandom;
    case ($urandom_range(0, 10))
      0: ins[6:0] = 7'h33;  1: ins[6:0] = 7'h13;  2: ins[6:0] = 7'h03;
      3: ins[6:0] = 7'h23;  4: ins[6:0] = 7'h63;  5: ins[6:0] = 7'h6F;
      6: ins[6:0] = 7'h67;  7: ins[6:0] = 7'h37;  8: ins[6:0] = 7'h17;
      9: ins[6:0] = 7'h03;  default: ins[6:0] = ($urandom_range(0, 1) != 0) ? 7'h7F : 7'h0B;
    endcase
    ins[11:7]  = 5'($urandom_range(0, 7));
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    return ins;
  endfunction

  task automatic test_reset();
    rst_n = 0; in_valid = 1; in_instr = I_ADD; out_ready = 1; flush = 0; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    step(); step();
    n_cmp++;
    if ({out_valid, op0, op1, imm, rs2_val, func3, func7, ctrl, rd, illegal} !== '0) begin
      n_fail++; $display("FAIL reset_outputs valid=%b op0=%h op1=%h ctrl=%h rd=%0d exp all 0", out_valid, op0, op1, ctrl, rd);
    end
    rst_n = 1; in_valid = 0;
  endtask

  task automatic test_add();
    in_valid = 1; in_instr = I_ADD; out_ready = 0; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL add_in_ready got %b exp 1", in_ready); end
    n_cmp++; if ({rs1_addr, rs2_addr} !== {5'd1, 5'd2}) begin n_fail++; $display("FAIL add_raddr got %0d/%0d exp 1/2", rs1_addr, rs2_addr); end
    step(); in_valid = 0;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got %b exp 1", out_valid); end
    n_cmp++; if ({op0, op1} !== {64'd5, 64'd7}) begin n_fail++; $display("FAIL add_ops got %h/%h exp 5/7", op0, op1); end
    n_cmp++; if ({func3, func7, ctrl, rd} !== {3'd0, 7'd0, 7'h60, 5'd3}) begin
      n_fail++; $display("FAIL add_ctrl got f3=%0d f7=%h ctrl=%h rd=%0d exp 0/0/60/3", func3, func7, ctrl, rd); end
    n_cmp++; if (rs2_val !== 64'd7) begin n_fail++; $display("FAIL add_rs2val got %h exp 7", rs2_val); end
    out_ready = 1; step();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_addi();
    in_valid = 1; in_instr = I_ADDI; out_ready = 1; step();
    in_instr = I_SRAI;
    n_cmp++; if ({op0, op1} !== {64'd0, 64'hFFFF_FFFF_FFFF_FC00}) begin
      n_fail++; $display("FAIL addi_ops got %h/%h exp 0/fffffffffffffc00", op0, op1); end
    n_cmp++; if ({func7, ctrl, rd} !== {7'd0, 7'h60, 5'd1}) begin
      n_fail++; $display("FAIL addi_ctrl got f7=%h ctrl=%h rd=%0d exp 0/60/1", func7, ctrl, rd); end
    step(); in_valid = 0;
    n_cmp++; if ({op0, op1, func3, func7} !== {64'd7, 64'h403, 3'd5, 7'h20}) begin
      n_fail++; $display("FAIL srai_fields got op0=%h op1=%h f3=%0d f7=%h exp 7/403/5/20", op0, op1, func3, func7); end
    step();
  endtask

  task automatic test_load_use();
    out_ready = 1; in_valid = 1; in_instr = I_LW5; step();
    n_cmp++; if (ctrl !== 7'h24) begin n_fail++; $display("FAIL lw_ctrl got %h exp 24", ctrl); end
    in_valid = 0; step();
    in_valid = 1; in_instr = I_ADD_DEP; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL lu_stall got %b exp 0", in_ready); end
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lu_release got %b exp 1", in_ready); end
    step(); in_valid = 0;
    n_cmp++; if ({out_valid, rd, op0} !== {1'b1, 5'd6, rf[5]}) begin
      n_fail++; $display("FAIL lu_issue got v=%b rd=%0d op0=%h exp 1/6/%h", out_valid, rd, op0, rf[5]); end
    in_valid = 1; in_instr = I_LW5; step();
    in_valid = 0; step();
    in_valid = 1; in_instr = I_ADD_IND; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lu_nostall got %b exp 1", in_ready); end
    step(); in_valid = 0;
    n_cmp++; if ({out_valid, rd, op0} !== {1'b1, 5'd6, rf[4]}) begin
      n_fail++; $display("FAIL lu_indep got v=%b rd=%0d op0=%h exp 1/6/%h", out_valid, rd, op0, rf[4]); end
    step();
  endtask

  task automatic test_backpressure();
    in_valid = 1; in_instr = I_ADD; out_ready = 1; step();
    out_ready = 0; in_instr = I_ADDI;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got %b exp 0", k, in_ready); end
      n_cmp++; if ({out_valid, op0, op1, rd, ctrl} !== {1'b1, 64'd5, 64'd7, 5'd3, 7'h60}) begin
        n_fail++; $display("FAIL bp_hold[%0d] got v=%b op0=%h op1=%h rd=%0d exp 1/5/7/3", k, out_valid, op0, op1, rd); end
      step();
    end
    out_ready = 1; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_resume got %b exp 1", in_ready); end
    step();
    n_cmp++; if ({out_valid, rd, op1} !== {1'b1, 5'd1, 64'hFFFF_FFFF_FFFF_FC00}) begin
      n_fail++; $display("FAIL b2b_first got v=%b rd=%0d op1=%h", out_valid, rd, op1); end
    in_instr = I_SRAI; step(); in_valid = 0;
    n_cmp++; if ({out_valid, func7, op1} !== {1'b1, 7'h20, 64'h403}) begin
      n_fail++; $display("FAIL b2b_second got v=%b f7=%h op1=%h exp 1/20/403", out_valid, func7, op1); end
    step();
  endtask

  task automatic test_flush();
    out_ready = 1; in_valid = 1; in_instr = I_LW5; step();
    in_instr = I_LW7; step();
    flush = 1; in_instr = I_ADD_DEP7; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b exp 0", in_ready); end
    step(); flush = 0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b exp 0", out_valid); end
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_cnt got ready %b exp 1", in_ready); end
    step();
    n_cmp++; if ({out_valid, rd, op0} !== {1'b1, 5'd6, rf[7]}) begin
      n_fail++; $display("FAIL flush_after got v=%b rd=%0d op0=%h exp 1/6/%h", out_valid, rd, op0, rf[7]); end
    in_instr = I_LW5; out_ready = 0; rst_n = 0; step();
    n_cmp++;
    if ({out_valid, op0, op1, imm, rs2_val, func3, func7, ctrl, rd, illegal} !== '0) begin
      n_fail++; $display("FAIL midreset got v=%b op0=%h ctrl=%h rd=%0d exp all 0", out_valid, op0, ctrl, rd); end
    rst_n = 1; in_valid = 0;
  endtask

  task automatic test_illegal();
    out_ready = 1; in_valid = 1; in_instr = 32'h0000007F; step(); in_valid = 0;
    n_cmp++; if ({out_valid, illegal, ctrl, op0, op1} !== {1'b1, 1'b1, 7'd0, 64'd0, 64'd0}) begin
      n_fail++; $display("FAIL illegal got v=%b ill=%b ctrl=%h op0=%h op1=%h exp 1/1/0/0/0", out_valid, illegal, ctrl, op0, op1); end
    step();
    n_cmp++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_qual got %b exp 0", illegal); end
  endtask

  task automatic test_bypass();
`ifdef ALU_ISSUE_BYPASS_EN
    logic [63:0] save;
    save = rf[1]; rf[1] = 64'd2;
    wb_en = 1; wb_rd = 5'd1; wb_data = 64'd9;
    out_ready = 1; in_valid = 1; in_instr = I_ADD; step(); in_valid = 0; wb_en = 0;
    n_cmp++; if (op0 !== 64'd9) begin n_fail++; $display("FAIL bypass_op0 got %h exp 9", op0); end
    rf[1] = save; step();
`endif
  endtask

  task automatic test_random();
    rst_n = 0; in_valid = 0; flush = 0; step(); step(); rst_n = 1;
    m_valid = 0; m_dec = '0; m_cnt = 0; m_ld = 0;
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      in_instr  = gen_instr();
      in_pc     = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rf[$urandom_range(0, 7)] = {$urandom, $urandom};
      #1;
      n_cmp++; if (in_ready !== ref_ready()) begin n_fail++; $display("FAIL rnd_ready c=%0d got %b exp %b", c, in_ready, ref_ready()); end
      n_cmp++; if (out_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid c=%0d got %b exp %b", c, out_valid, m_valid); end
      n_cmp++; if (illegal !== (m_valid & m_dec.ill)) begin n_fail++; $display("FAIL rnd_illegal c=%0d got %b exp %b", c, illegal, m_valid & m_dec.ill); end
      if (m_valid) begin
        n_cmp++; if ({op0, op1} !== {m_dec.op0, m_dec.op1}) begin
          n_fail++; $display("FAIL rnd_ops c=%0d got %h/%h exp %h/%h", c, op0, op1, m_dec.op0, m_dec.op1); end
        n_cmp++; if ({func3, ctrl, rd, rs2_val} !== {m_dec.f3, m_dec.ctrl, m_dec.rd, m_dec.rs2v}) begin
          n_fail++; $display("FAIL rnd_ctrl c=%0d got f3=%0d ctrl=%h rd=%0d r2=%h exp %0d/%h/%0d/%h", c, func3, ctrl, rd, rs2_val, m_dec.f3, m_dec.ctrl, m_dec.rd, m_dec.rs2v); end
        if (m_dec.chk_f7) begin
          n_cmp++; if (func7 !== m_dec.f7) begin n_fail++; $display("FAIL rnd_func7 c=%0d got %h exp %h", c, func7, m_dec.f7); end
        end
        if (m_dec.chk_imm) begin
          n_cmp++; if (imm !== m_dec.imm) begin n_fail++; $display("FAIL rnd_imm c=%0d got %h exp %h", c, imm, m_dec.imm); end
        end
      end
      model_edge();
      step();
    end
    in_valid = 0; flush = 0;
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_instr = '0; in_pc = 64'h1000; out_ready = 0; flush = 0;
    wb_en = 0; wb_rd = '0; wb_data = '0;
    for (int r = 0; r < 32; r++) rf[r] = {$urandom, $urandom};
    rf[0] = 64'd123; rf[1] = 64'd5; rf[2] = 64'd7;
    test_reset();
    test_add();
    test_addi();
    test_load_use();
    test_backpressure();
    test_flush();
    test_illegal();
    test_bypass();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
